// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache arbiter in front of physical memory.
// FSM states, grant sides and datapath widths live here.
package arbiter_types;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_arbiter.sv
// Two-port cache arbiter: I-cache reads and D-cache reads/writebacks share one pmem port.
// A request is latched on grant and replayed to pmem unchanged until pmem_resp.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    arb_state_t        r_state;
    grant_t            r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;

    logic w_i_req, w_d_req, w_grant_d, w_busy;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    // D wins when alone, under fixed priority, or when I was served last.
    assign w_grant_d = w_d_req & (~w_i_req | ~RR_EN | (r_last_grant == GRANT_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_I;
            r_addr       <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= ARB_DCACHE;
                        r_last_grant <= GRANT_D;
                        r_addr       <= d_address;
                        r_write      <= d_write;
                        r_read       <= ~d_write;
                        r_wdata      <= d_wdata;
                    end else if (w_i_req) begin
                        r_state      <= ARB_ICACHE;
                        r_last_grant <= GRANT_I;
                        r_addr       <= i_address;
                        r_write      <= 1'b0;
                        r_read       <= 1'b1;
                        r_wdata      <= '0;
                    end
                end
                ARB_ICACHE, ARB_DCACHE: begin
                    if (pmem_resp) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign w_busy       = (r_state != ARB_IDLE);
    assign pmem_address = w_busy ? r_addr  : '0;
    assign pmem_read    = w_busy & r_read;
    assign pmem_write   = w_busy & r_write;
    assign pmem_wdata   = w_busy ? r_wdata : '0;

    // Completion is combinational so the cache sees data in the pmem_resp cycle.
    assign i_resp  = (r_state == ARB_ICACHE) & pmem_resp;
    assign d_resp  = (r_state == ARB_DCACHE) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a round-robin and a fixed-priority instance run in lockstep
// against a transaction-level grant model; memory latency and requester noise are random.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0]  i_address = '0, d_address = '0;
    logic         i_read = 0, d_read = 0, d_write = 0;
    logic [255:0] d_wdata = '0, pmem_rdata = '0;
    logic         pmem_resp = 0;

    logic [1:0][255:0] i_rdata, d_rdata, pmem_wdata;
    logic [1:0][31:0]  pmem_address;
    logic [1:0]        i_resp, d_resp, pmem_read, pmem_write;

    int checks = 0;
    int fails  = 0;
    bit last_d [2];          // model: 1 when D was granted last
    bit rr_mode [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    cache_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .pmem_address(pmem_address[0]), .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    cache_arbiter #(.RR_EN(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .pmem_address(pmem_address[1]), .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input int n, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        for (int n = 0; n < 2; n++) begin
            chk({tag, "_paddr"}, n, pmem_address[n], '0);
            chk({tag, "_prd_pwr"}, n, {pmem_read[n], pmem_write[n]}, '0);
            chk({tag, "_pwdata"}, n, pmem_wdata[n], '0);
            chk({tag, "_resp"}, n, {i_resp[n], d_resp[n]}, '0);
            chk({tag, "_rdata"}, n, i_rdata[n] | d_rdata[n], '0);
        end
    endtask

    task automatic clear_reqs();
        i_read = 0; d_read = 0; d_write = 0;
    endtask

    // Entered just after a rising edge with both DUTs idle; leaves them idle the same way.
    task automatic txn(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic [255:0] wd, input int lat,
                       input bit noise, input string tag);
        bit g_d [2];
        logic [31:0] e_addr [2];
        bit e_rd [2], e_wr [2];
        logic [255:0] rd;
        i_read = ir; d_read = dr; d_write = dw;
        i_address = ia; d_address = da; d_wdata = wd;
        for (int n = 0; n < 2; n++) begin
            if (ir && (dr || dw)) g_d[n] = rr_mode[n] ? !last_d[n] : 1'b1;
            else                  g_d[n] = (dr || dw);
            e_addr[n] = g_d[n] ? da : ia;
            e_wr[n]   = g_d[n] && dw;
            e_rd[n]   = !e_wr[n];
            if (ir || dr || dw) last_d[n] = g_d[n];
        end
        @(negedge clk);
        chk_quiet({tag, "_idle"});
        @(posedge clk); #1;
        if (!(ir || dr || dw)) return;
        for (int k = 0; k <= lat; k++) begin
            if (noise) begin
                i_read = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
                i_address = $urandom; d_address = 32'hDEAD_BEE0;
                d_wdata = {8{$urandom}};
            end
            if (k == lat) begin
                rd = {8{$urandom}};
                pmem_rdata = rd; pmem_resp = 1;
            end
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                chk({tag, "_paddr"}, n, pmem_address[n], e_addr[n]);
                chk({tag, "_prd"}, n, pmem_read[n], e_rd[n]);
                chk({tag, "_pwr"}, n, pmem_write[n], e_wr[n]);
                if (e_wr[n]) chk({tag, "_pwdata"}, n, pmem_wdata[n], wd);
                if (k == lat) begin
                    chk({tag, "_iresp"}, n, i_resp[n], !g_d[n]);
                    chk({tag, "_dresp"}, n, d_resp[n], g_d[n]);
                    chk({tag, "_irdata"}, n, i_rdata[n], g_d[n] ? 256'd0 : rd);
                    chk({tag, "_drdata"}, n, d_rdata[n], g_d[n] ? rd : 256'd0);
                end else begin
                    chk({tag, "_resp_early"}, n, {i_resp[n], d_resp[n]}, '0);
                end
            end
            @(posedge clk); #1;
        end
        pmem_resp = 0; pmem_rdata = '0;
        clear_reqs();
    endtask

    initial begin
        last_d[0] = 0; last_d[1] = 0;
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Tie sequence right after reset: RR gives D,I,D,I; fixed gives D every time.
        for (int t = 0; t < 4; t++)
            txn(1, 1, 0, 32'h0000_3000 + t, 32'h0000_4000 + t, '0, 1, 0, "tie");

        // I-only line read, then a D writeback.
        txn(1, 0, 0, 32'h0000_1000, '0, '0, 3, 0, "ionly");
        txn(0, 0, 1, '0, 32'h0000_2040, {64{4'h5}}, 2, 0, "dwb");
        // Read+write together is a write; requester noise must not disturb the latched request.
        txn(0, 1, 1, '0, 32'h0000_2080, {64{4'hC}}, 3, 1, "drw_noise");
        txn(1, 0, 0, 32'h0000_5000, '0, '0, 0, 1, "i_lat0");

        // Spurious pmem_resp while idle.
        pmem_resp = 1; pmem_rdata = {64{4'hF}};
        @(negedge clk);
        chk_quiet("spurious");
        @(posedge clk); #1;
        pmem_resp = 0; pmem_rdata = '0;

        // Reset two cycles into an I read: outputs drop at once, no resp, next tie goes to D.
        i_read = 1; i_address = 32'h0000_6000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk_quiet("midrst");
        pmem_resp = 1; pmem_rdata = {64{4'hA}};
        @(negedge clk);
        chk_quiet("midrst_resp");
        @(posedge clk); #1;
        pmem_resp = 0; pmem_rdata = '0; rst = 0; clear_reqs();
        last_d[0] = 0; last_d[1] = 0;
        txn(1, 1, 0, 32'h0000_7000, 32'h0000_8000, '0, 1, 0, "tie_after_rst");

        for (int r = 0; r < 60; r++)
            txn(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, {8{$urandom}},
                int'($urandom_range(0, 4)), 1'($urandom), "rand");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
